// File: rtl/rob_retire_ctrl.sv
// rob_retire_ctrl: in-order retirement controller at the ROB dequeue end.
// Retires at most one head entry per cycle. A completed entry is written to
// the architectural register file. An excepting entry is dropped and raises a
// one-cycle flush request; retirement then holds off until flush_done.
// Optional feature macro: RETIRE_PERF_CTR_EN adds the retired_count port.
module rob_retire_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ARCH_REG_W  = 5,
    parameter int N_ENTRIES   = 8,
    localparam int PTR_WIDTH   = $clog2(N_ENTRIES),
    localparam int ENTRY_WIDTH = DATA_WIDTH + ARCH_REG_W + 3
) (
    input  logic                   clk,
    input  logic                   rst_aL,
    input  logic                   deq_valid,
    output logic                   deq_ready,
    input  logic [ENTRY_WIDTH-1:0] deq_data,
    input  logic [PTR_WIDTH-1:0]   deq_addr,
    output logic                   arf_we,
    output logic [ARCH_REG_W-1:0]  arf_waddr,
    output logic [DATA_WIDTH-1:0]  arf_wdata,
    output logic [PTR_WIDTH-1:0]   arf_rob_id,
    output logic                   flush_valid,
    output logic [PTR_WIDTH-1:0]   flush_rob_id,
    input  logic                   flush_done
`ifdef RETIRE_PERF_CTR_EN
    ,
    output logic [31:0]            retired_count
`endif
);

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_FLUSH = 1'b1;

    // Head entry field decode
    logic                  ent_done;
    logic                  ent_exc;
    logic                  ent_has_dst;
    logic [ARCH_REG_W-1:0] ent_dst;
    logic [DATA_WIDTH-1:0] ent_result;

    assign ent_done    = deq_data[0];
    assign ent_exc     = deq_data[1];
    assign ent_has_dst = deq_data[2];
    assign ent_dst     = deq_data[ARCH_REG_W+2:3];
    assign ent_result  = deq_data[ENTRY_WIDTH-1:ARCH_REG_W+3];

    logic                  state_q,        state_d;
    logic                  arf_we_q,       arf_we_d;
    logic [ARCH_REG_W-1:0] arf_waddr_q,    arf_waddr_d;
    logic [DATA_WIDTH-1:0] arf_wdata_q,    arf_wdata_d;
    logic [PTR_WIDTH-1:0]  arf_rob_id_q,   arf_rob_id_d;
    logic                  flush_valid_q,  flush_valid_d;
    logic [PTR_WIDTH-1:0]  flush_rob_id_q, flush_rob_id_d;
    logic                  pop;

    // Pop handshake: only in RUN, and only when the head has completed.
    // flush_done deliberately does not feed this path.
    always_comb begin
        deq_ready = (state_q == ST_RUN) && deq_valid && ent_done;
        pop       = deq_valid && deq_ready;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d        = state_q;
        arf_we_d       = 1'b0;
        arf_waddr_d    = arf_waddr_q;
        arf_wdata_d    = arf_wdata_q;
        arf_rob_id_d   = arf_rob_id_q;
        flush_valid_d  = 1'b0;
        flush_rob_id_d = flush_rob_id_q;
        case (state_q)
            ST_RUN: begin
                if (pop) begin
                    if (ent_exc) begin
                        // Excepting entry: no writeback, request a flush
                        flush_valid_d  = 1'b1;
                        flush_rob_id_d = deq_addr;
                        state_d        = ST_FLUSH;
                    end else begin
                        // x0 writes are passed through; the ARF discards them
                        arf_we_d     = ent_has_dst;
                        arf_waddr_d  = ent_dst;
                        arf_wdata_d  = ent_result;
                        arf_rob_id_d = deq_addr;
                    end
                end
            end
            default: begin
                if (flush_done) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q        <= ST_RUN;
            arf_we_q       <= 1'b0;
            arf_waddr_q    <= '0;
            arf_wdata_q    <= '0;
            arf_rob_id_q   <= '0;
            flush_valid_q  <= 1'b0;
            flush_rob_id_q <= '0;
        end else begin
            state_q        <= state_d;
            arf_we_q       <= arf_we_d;
            arf_waddr_q    <= arf_waddr_d;
            arf_wdata_q    <= arf_wdata_d;
            arf_rob_id_q   <= arf_rob_id_d;
            flush_valid_q  <= flush_valid_d;
            flush_rob_id_q <= flush_rob_id_d;
        end
    end

    assign arf_we       = arf_we_q;
    assign arf_waddr    = arf_waddr_q;
    assign arf_wdata    = arf_wdata_q;
    assign arf_rob_id   = arf_rob_id_q;
    assign flush_valid  = flush_valid_q;
    assign flush_rob_id = flush_rob_id_q;

`ifdef RETIRE_PERF_CTR_EN
    logic [31:0] retired_count_q, retired_count_d;

    // Count every pop, excepting ones included; wraps naturally
    always_comb begin
        retired_count_d = retired_count_q + {31'd0, pop};
    end

    // Performance counter register
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            retired_count_q <= '0;
        end else begin
            retired_count_q <= retired_count_d;
        end
    end

    assign retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Directed testbench for rob_retire_ctrl (default 32/5/8 configuration).
module tb_rob_retire_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int PW = 3;
    localparam int EW = DW + AW + 3;

    logic          clk = 1'b0;
    logic          rst_aL;
    logic          deq_valid;
    logic          deq_ready;
    logic [EW-1:0] deq_data;
    logic [PW-1:0] deq_addr;
    logic          arf_we;
    logic [AW-1:0] arf_waddr;
    logic [DW-1:0] arf_wdata;
    logic [PW-1:0] arf_rob_id;
    logic          flush_valid;
    logic [PW-1:0] flush_rob_id;
    logic          flush_done;
`ifdef RETIRE_PERF_CTR_EN
    logic [31:0]   retired_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rob_retire_ctrl dut (
        .clk          (clk),
        .rst_aL       (rst_aL),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .deq_data     (deq_data),
        .deq_addr     (deq_addr),
        .arf_we       (arf_we),
        .arf_waddr    (arf_waddr),
        .arf_wdata    (arf_wdata),
        .arf_rob_id   (arf_rob_id),
        .flush_valid  (flush_valid),
        .flush_rob_id (flush_rob_id),
        .flush_done   (flush_done)
`ifdef RETIRE_PERF_CTR_EN
        ,
        .retired_count(retired_count)
`endif
    );

    function automatic logic [EW-1:0] mk(input logic done, input logic exc,
                                         input logic has_dst, input logic [AW-1:0] dst,
                                         input logic [DW-1:0] res);
        return {res, dst, has_dst, exc, done};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_count(input string tag, input logic [31:0] exp);
`ifdef RETIRE_PERF_CTR_EN
        chk(tag, {32'd0, retired_count}, {32'd0, exp});
`else
        if (exp === 32'hffff_ffff) $display("unused %s", tag);
`endif
    endtask

    initial begin
        logic [PW-1:0] wrap_ids [4];
        wrap_ids = '{3'd6, 3'd7, 3'd0, 3'd1};

        rst_aL = 1'b0; deq_valid = 1'b0; deq_data = '0; deq_addr = '0; flush_done = 1'b0;
        #2;
        // Reset state
        chk("rst_ready", {63'd0, deq_ready}, 64'd0);
        chk("rst_we", {63'd0, arf_we}, 64'd0);
        chk("rst_waddr", {59'd0, arf_waddr}, 64'd0);
        chk("rst_wdata", {32'd0, arf_wdata}, 64'd0);
        chk("rst_robid", {61'd0, arf_rob_id}, 64'd0);
        chk("rst_flush", {63'd0, flush_valid}, 64'd0);
        chk("rst_flush_id", {61'd0, flush_rob_id}, 64'd0);
        chk_count("rst_count", 32'd0);
        tick;
        rst_aL = 1'b1;

        // Idle: three cycles with no valid head
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("idle_ready", {63'd0, deq_ready}, 64'd0);
            chk("idle_we", {63'd0, arf_we}, 64'd0);
            chk("idle_flush", {63'd0, flush_valid}, 64'd0);
        end

        // Three back-to-back done entries: IDs 5,6,7 dst 1,2,3 result A,B,C
        for (int i = 0; i < 3; i++) begin
            deq_valid = 1'b1;
            deq_data  = mk(1'b1, 1'b0, 1'b1, AW'(i + 1), DW'(32'hA + i));
            deq_addr  = PW'(5 + i);
            #1;
            chk("b2b_ready", {63'd0, deq_ready}, 64'd1);
            tick;
            chk("b2b_we", {63'd0, arf_we}, 64'd1);
            chk("b2b_waddr", {59'd0, arf_waddr}, 64'(i + 1));
            chk("b2b_wdata", {32'd0, arf_wdata}, 64'(32'hA + i));
            chk("b2b_robid", {61'd0, arf_rob_id}, 64'(5 + i));
            $display("retire id=%0d dst=%0d data=%0h", arf_rob_id, arf_waddr, arf_wdata);
        end
        deq_valid = 1'b0;
        chk_count("b2b_count", 32'd3);

        // Head not done for 4 cycles, then done with no destination
        deq_valid = 1'b1;
        deq_data  = mk(1'b0, 1'b0, 1'b0, 5'd4, 32'h55);
        deq_addr  = 3'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_ready", {63'd0, deq_ready}, 64'd0);
            tick;
            chk("stall_we", {63'd0, arf_we}, 64'd0);
        end
        deq_data = mk(1'b1, 1'b0, 1'b0, 5'd4, 32'h55);
        #1;
        chk("nodst_ready", {63'd0, deq_ready}, 64'd1);
        tick;
        chk("nodst_we", {63'd0, arf_we}, 64'd0);
        chk("nodst_flush", {63'd0, flush_valid}, 64'd0);
        chk_count("nodst_count", 32'd4);

        // Exception at ID 7, next entry waiting, flush_done 2 cycles after flush_valid
        deq_data = mk(1'b1, 1'b1, 1'b1, 5'd3, 32'h99);
        deq_addr = 3'd7;
        #1;
        chk("exc_ready", {63'd0, deq_ready}, 64'd1);
        tick;
        chk("exc_flush", {63'd0, flush_valid}, 64'd1);
        chk("exc_flush_id", {61'd0, flush_rob_id}, 64'd7);
        chk("exc_we", {63'd0, arf_we}, 64'd0);
        deq_data = mk(1'b1, 1'b0, 1'b1, 5'd9, 32'h1234);
        deq_addr = 3'd0;
        #1;
        chk("fl_ready0", {63'd0, deq_ready}, 64'd0);
        tick;
        chk("fl_flush_pulse", {63'd0, flush_valid}, 64'd0);
        chk("fl_ready1", {63'd0, deq_ready}, 64'd0);
        tick;
        flush_done = 1'b1;
        #1;
        chk("fl_ready_done", {63'd0, deq_ready}, 64'd0);
        tick;
        flush_done = 1'b0;
        #1;
        chk("post_fl_ready", {63'd0, deq_ready}, 64'd1);
        chk("post_fl_we0", {63'd0, arf_we}, 64'd0);
        tick;
        chk("post_fl_we", {63'd0, arf_we}, 64'd1);
        chk("post_fl_waddr", {59'd0, arf_waddr}, 64'd9);
        chk("post_fl_wdata", {32'd0, arf_wdata}, 64'h1234);
        chk("post_fl_robid", {61'd0, arf_rob_id}, 64'd0);
        deq_valid = 1'b0;
        chk_count("post_fl_count", 32'd6);

        // Reset asserted mid-FLUSH
        deq_valid = 1'b1;
        deq_data  = mk(1'b1, 1'b1, 1'b0, 5'd1, 32'h1);
        deq_addr  = 3'd3;
        tick;
        chk("rf_flush", {63'd0, flush_valid}, 64'd1);
        chk("rf_flush_id", {61'd0, flush_rob_id}, 64'd3);
        deq_valid = 1'b0;
        #2;
        rst_aL = 1'b0;
        #1;
        chk("rf_flush_clr", {63'd0, flush_valid}, 64'd0);
        chk("rf_flush_id_clr", {61'd0, flush_rob_id}, 64'd0);
        chk("rf_waddr_clr", {59'd0, arf_waddr}, 64'd0);
        chk("rf_wdata_clr", {32'd0, arf_wdata}, 64'd0);
        chk("rf_robid_clr", {61'd0, arf_rob_id}, 64'd0);
        chk_count("rf_count_clr", 32'd0);
        #1;
        rst_aL = 1'b1;
        deq_valid = 1'b1;
        deq_data  = mk(1'b1, 1'b0, 1'b1, 5'd2, 32'h77);
        deq_addr  = 3'd4;
        #1;
        chk("rf_run_ready", {63'd0, deq_ready}, 64'd1);
        tick;
        chk("rf_we", {63'd0, arf_we}, 64'd1);
        chk("rf_wdata", {32'd0, arf_wdata}, 64'h77);
        chk("rf_robid", {61'd0, arf_rob_id}, 64'd4);

        // ROB ID wrap: 6,7,0,1
        for (int i = 0; i < 4; i++) begin
            deq_data = mk(1'b1, 1'b0, 1'b1, AW'(i + 5), DW'(32'h100 + i));
            deq_addr = wrap_ids[i];
            #1;
            chk("wrap_ready", {63'd0, deq_ready}, 64'd1);
            tick;
            chk("wrap_we", {63'd0, arf_we}, 64'd1);
            chk("wrap_robid", {61'd0, arf_rob_id}, {61'd0, wrap_ids[i]});
            chk("wrap_flush", {63'd0, flush_valid}, 64'd0);
            $display("retire id=%0d dst=%0d data=%0h", arf_rob_id, arf_waddr, arf_wdata);
        end
        deq_valid = 1'b0;
        chk_count("wrap_count", 32'd5);
        tick;
        chk("end_we", {63'd0, arf_we}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
